// File: rtl/clk_enable_gen_if.sv
// Control and status bundle for clk_enable_gen: divisor load, mode, step request,
// and the enable pulse with its pulse counter and blink phase.
interface clk_enable_gen_if #(
  parameter int CNT_WIDTH   = 21,
  parameter int COUNT_WIDTH = 16
);
  logic                   div_load;
  logic [CNT_WIDTH-1:0]   div_value;
  logic [1:0]             mode;
  logic                   step_req;
  logic                   ce;
  logic [COUNT_WIDTH-1:0] ce_count;
  logic                   phase;

  modport master (
    output div_load, div_value, mode, step_req,
    input  ce, ce_count, phase
  );

  modport slave (
    input  div_load, div_value, mode, step_req,
    output ce, ce_count, phase
  );
endinterface

// File: rtl/clk_enable_gen.sv
// Programmable clock-enable generator: one-cycle ce pulse every div_reg+1 clk
// cycles in run mode, frozen in halt, one pulse per step_req rising edge in step mode.
module clk_enable_gen #(
  parameter int          CNT_WIDTH   = 21,
  parameter int unsigned RESET_DIV   = 1048575,
  parameter int          COUNT_WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  clk_enable_gen_if.slave  bus
);
  typedef enum logic [1:0] {
    MODE_RUN  = 2'b00,
    MODE_HALT = 2'b01,
    MODE_STEP = 2'b10,
    MODE_RSVD = 2'b11
  } mode_e;

  localparam logic [CNT_WIDTH-1:0] RESET_DIV_V = CNT_WIDTH'(RESET_DIV);

  logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;
  logic [CNT_WIDTH-1:0]   div_reg, div_next;
  logic                   step_q_reg;
  logic                   ce_reg, ce_next;
  logic [COUNT_WIDTH-1:0] ce_count_reg, ce_count_next;
  logic                   phase_reg, phase_next;
  mode_e                  mode_cur;

  assign mode_cur = mode_e'(bus.mode);

  always_comb begin
    cnt_next      = cnt_reg;
    div_next      = div_reg;
    ce_next       = 1'b0;
    if (bus.div_load) begin
      // A load restarts the period and suppresses any pulse due this cycle.
      div_next = bus.div_value;
      cnt_next = '0;
    end else begin
      case (mode_cur)
        MODE_RUN: begin
          if (cnt_reg == div_reg) begin
            cnt_next = '0;
            ce_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_WIDTH'(1);
          end
        end
        MODE_STEP: begin
          cnt_next = '0;
          ce_next  = bus.step_req & ~step_q_reg;
        end
        default: begin
          cnt_next = cnt_reg;
        end
      endcase
    end
    ce_count_next = ce_count_reg + {{(COUNT_WIDTH-1){1'b0}}, ce_next};
    phase_next    = phase_reg ^ ce_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_reg      <= '0;
      div_reg      <= RESET_DIV_V;
      step_q_reg   <= 1'b0;
      ce_reg       <= 1'b0;
      ce_count_reg <= '0;
      phase_reg    <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      div_reg      <= div_next;
      // Edge detector history follows step_req in every mode.
      step_q_reg   <= bus.step_req;
      ce_reg       <= ce_next;
      ce_count_reg <= ce_count_next;
      phase_reg    <= phase_next;
    end
  end

  assign bus.ce       = ce_reg;
  assign bus.ce_count = ce_count_reg;
  assign bus.phase    = phase_reg;
endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed scenarios plus random traffic,
// scored per cycle against a pulse-counting reference model.
module tb_clk_enable_gen;
  localparam int CW  = 10;
  localparam int RD  = 200;
  localparam int CNW = 8;

  typedef struct packed {
    logic           ce;
    logic [CNW-1:0] cnt;
    logic           phase;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  clk_enable_gen_if #(.CNT_WIDTH(CW), .COUNT_WIDTH(CNW)) bus ();

  clk_enable_gen #(.CNT_WIDTH(CW), .RESET_DIV(RD), .COUNT_WIDTH(CNW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];
  bit   started = 0;

  // Reference model: position within the current period, divisor, last step level,
  // and the total number of pulses ever issued since reset.
  int m_pos, m_div, m_prev, m_pulses;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model_step(input logic rst, input logic ld, input int val,
                                      input logic [1:0] md, input logic stp);
    exp_t e;
    int pulse;
    pulse = 0;
    if (rst) begin
      m_pos = 0; m_div = RD; m_prev = 0; m_pulses = 0;
    end else begin
      if (ld) begin
        m_div = val; m_pos = 0;
      end else if (md == 2'b00) begin
        if (m_pos == m_div) begin pulse = 1; m_pos = 0; end
        else m_pos = m_pos + 1;
      end else if (md == 2'b10) begin
        m_pos = 0;
        pulse = (stp && m_prev == 0) ? 1 : 0;
      end
      m_prev = stp ? 1 : 0;
      m_pulses = m_pulses + pulse;
    end
    e.ce    = (pulse != 0);
    e.cnt   = CNW'(m_pulses % (1 << CNW));
    e.phase = m_pulses[0];
    return e;
  endfunction

  task automatic cycle(input logic rst, input logic ld, input int val,
                       input logic [1:0] md, input logic stp);
    @(negedge clk);
    reset         = rst;
    bus.div_load  = ld;
    bus.div_value = CW'(val);
    bus.mode      = md;
    bus.step_req  = stp;
    expq.push_back(model_step(rst, ld, val, md, stp));
    started = 1;
    @(posedge clk);
    #1;
  endtask

  // Monitor: the DUT presents a fresh output every clock; compare it with the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (started) begin
      if (expq.size() == 0) begin
        chk("scoreboard_underflow", 1, 0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("ce", int'(bus.ce), int'(e.ce));
        chk("ce_count", int'(bus.ce_count), int'(e.cnt));
        chk("phase", int'(bus.phase), int'(e.phase));
        if (bus.ce) $display("ce pulse: ce_count=%0d phase=%0d", bus.ce_count, bus.phase);
      end
    end
  end

  initial begin
    int first_ce, second_ce, n_pulse;
    logic [1:0] md;
    logic stp;
    reset = 1'b1; bus.div_load = 1'b0; bus.div_value = '0; bus.mode = 2'b00; bus.step_req = 1'b0;

    // Reset, then free-run at the reset divisor
    repeat (3) cycle(1, 0, 0, 2'b00, 0);
    chk("reset_ce", int'(bus.ce), 0);
    chk("reset_count", int'(bus.ce_count), 0);
    first_ce = -1; second_ce = -1;
    for (int i = 0; i < 2 * (RD + 1) + 10 && second_ce < 0; i++) begin
      cycle(0, 0, 0, 2'b00, 0);
      if (bus.ce) begin
        if (first_ce < 0) first_ce = i + 1;
        else second_ce = i + 1;
      end
    end
    chk("first_ce_cycle", first_ce, RD + 1);
    chk("second_ce_cycle", second_ce, 2 * (RD + 1));
    chk("count_after_two", int'(bus.ce_count), 2);
    chk("phase_after_two", int'(bus.phase), 0);

    // Divisor 3: pulse every 4th cycle
    cycle(0, 1, 3, 2'b00, 0);
    chk("load_suppresses_ce", int'(bus.ce), 0);
    n_pulse = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(0, 0, 0, 2'b00, 0);
      if (bus.ce) n_pulse++;
    end
    chk("div3_pulses_in_20", n_pulse, 5);

    // Divisor 0: ce every cycle, ce_count wraps
    cycle(0, 1, 0, 2'b00, 0);
    repeat (300) cycle(0, 0, 0, 2'b00, 0);

    // Divisor 9: halt at cnt=5, then resume
    cycle(0, 1, 9, 2'b00, 0);
    repeat (5) cycle(0, 0, 0, 2'b00, 0);
    n_pulse = 0;
    for (int i = 0; i < 7; i++) begin
      cycle(0, 0, 0, (i % 2 == 0) ? 2'b01 : 2'b11, 0);
      if (bus.ce) n_pulse++;
    end
    chk("halt_no_pulse", n_pulse, 0);
    repeat (4) cycle(0, 0, 0, 2'b00, 0);
    chk("resume_pre_pulse", int'(bus.ce), 0);
    cycle(0, 0, 0, 2'b00, 0);
    chk("resume_pulse_5", int'(bus.ce), 1);

    // Step mode: high 10, low 2, high 1, low 4
    n_pulse = 0;
    for (int i = 0; i < 17; i++) begin
      cycle(0, 0, 0, 2'b10, (i < 10 || i == 12) ? 1'b1 : 1'b0);
      if (bus.ce) n_pulse++;
    end
    chk("step_pulses", n_pulse, 2);

    // Load coincident with terminal count
    cycle(0, 1, 4, 2'b00, 0);
    repeat (4) cycle(0, 0, 0, 2'b00, 0);
    cycle(0, 1, 4, 2'b00, 0);
    chk("load_at_terminal", int'(bus.ce), 0);
    repeat (3) cycle(0, 0, 0, 2'b00, 0);

    // Reset mid-count
    cycle(1, 0, 0, 2'b00, 0);
    chk("midreset_ce", int'(bus.ce), 0);
    chk("midreset_count", int'(bus.ce_count), 0);
    chk("midreset_phase", int'(bus.phase), 0);

    // Random traffic
    md = 2'b00; stp = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 14) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 2) == 0) stp = ~stp;
      cycle(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
            int'($urandom_range(0, 12)), md, stp);
    end

    @(negedge clk);
    chk("scoreboard_drained", expq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_enable_gen.md
Name: clk_enable_gen

Overview:
- Parametrised successor to the free-running divider that derives the SoC clock from a counter MSB.
- Produces a single-cycle clock-enable pulse `ce` at a programmable rate, in the fast `clk` domain. The Z8 SoC and its peripherals run on `clk` gated by `ce`, instead of on a derived clock.
- Adds run, halt and single-step modes, runtime divisor load, an enable counter and a blink phase output for LED use.

Parameters:
- CNT_WIDTH, 21: width of the prescale counter and of the divisor.
- RESET_DIV, 1048575: divisor terminal value loaded on reset. Pulse period is RESET_DIV+1 clk cycles.
- COUNT_WIDTH, 16: width of the issued-enable counter.

Ports:
- clk, input, 1: system clock, the only clock. All logic is on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- div_load, input, 1: load div_value into the divisor register this cycle.
- div_value, input, CNT_WIDTH: new terminal count. Period is div_value+1 cycles.
- mode, input, 2: 00 run, 01 halt, 10 single-step, 11 reserved (treated as halt).
- step_req, input, 1: single-step request. Only its rising edge is used, and only in step mode.
- ce, output, 1: one-clk-wide enable pulse, registered.
- ce_count, output, COUNT_WIDTH: number of ce pulses issued, modulo 2^COUNT_WIDTH.
- phase, output, 1: toggles on every ce pulse (square wave at half the ce rate).

Behaviour:
Reset:
- Internal state: cnt=0, div_reg=RESET_DIV, step_q=0.
- Outputs: ce=0, ce_count=0, phase=0.
- Reset wins over every other input. Asserting reset mid-operation returns everything to these values at the next edge.

Run mode (00):
- cnt counts 0..div_reg. When cnt==div_reg, cnt wraps to 0 at the next edge; otherwise cnt increments.
- ce is registered: ce <= (cnt==div_reg). ce is therefore high for the one cycle after the terminal count.
- First ce after reset release is high in cycle RESET_DIV+1, counting the first non-reset cycle as cycle 0.
- div_reg=0 gives ce high every cycle, continuously.

Halt mode (01 or 11):
- cnt frozen and ce=0.
- Returning to run resumes counting from the frozen cnt value. The prescale phase is not lost.

Step mode (10):
- cnt is held at 0.
- step_q registers step_req each cycle.
- A detected rising edge (step_req=1 and step_q=0) drives ce=1 on the next cycle, for exactly one cycle.
- Holding step_req high produces one pulse only. A new pulse needs step_req to go low for at least one cycle, then high again.
- step_q tracks step_req in all modes. Entering step mode while step_req is already high therefore produces no pulse.

Mode transitions:
- Leaving step mode for run mode: counting starts at cnt=0.
- A step edge in the same cycle that mode changes away from 10 is ignored.

Divisor load:
- On div_load=1: div_reg <= div_value and cnt <= 0, and ce is 0 in the following cycle.
- Load has priority over a terminal count in the same cycle, so no pulse is produced for that period.
- Load is accepted in every mode. In halt mode the cnt reset still happens.

ce_count and phase:
- Both update in the same cycle that ce is high: ce_count+1, with natural wrap from all-ones to 0, and phase inverted.
- Both change in any mode that emits ce.

Width rules:
- cnt and div_reg are unsigned CNT_WIDTH. There are no signed or overflow cases beyond the wrap at div_reg.

Test Plan:
- Reset with defaults, mode=00, 2.2M cycles -> first ce in cycle 1048576, second in cycle 2097152; ce_count=2 and phase=0 after the second pulse.
- div_load with div_value=3, then run 20 cycles -> ce high on every 4th cycle, each pulse exactly 1 cycle wide; phase toggles on each pulse.
- div_value=0 -> ce high continuously; ce_count increments every cycle and wraps from 0xFFFF to 0x0000.
- div_value=9: halt at cnt=5 for 7 cycles, then resume -> no ce while halted; next ce 5 cycles after resume (cnt 5..9, pulse on the following cycle).
- mode=10: step_req held high 10 cycles, low 2, high 1 -> exactly two ce pulses, each 1 cycle after its rising edge; no pulses otherwise.
- div_load asserted in the same cycle cnt==div_reg -> no ce the following cycle. Reset asserted mid-count -> ce=0, ce_count=0, phase=0, div_reg=RESET_DIV next cycle.
